// File: rtl/m_div_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module      : m_div_sequencer_if
// Description : Request/response bus between the execute stage (master) and
//               the divide sequencer (slave).
// Revision    : 1.0 - initial release
// ============================================================================
interface m_div_sequencer_if #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 5
);
  logic             req_valid;
  logic             req_ready;
  logic [3:0]       req_op;
  logic [XLEN-1:0]  req_a;
  logic [XLEN-1:0]  req_b;
  logic [TAG_W-1:0] req_tag;
  logic             resp_valid;
  logic             resp_ready;
  logic [XLEN-1:0]  resp_data;
  logic [TAG_W-1:0] resp_tag;

  // Execute-stage side
  modport master (
    output req_valid, req_op, req_a, req_b, req_tag, resp_ready,
    input  req_ready, resp_valid, resp_data, resp_tag
  );

  // Sequencer side
  modport slave (
    input  req_valid, req_op, req_a, req_b, req_tag, resp_ready,
    output req_ready, resp_valid, resp_data, resp_tag
  );
endinterface
`default_nettype wire

// File: rtl/m_div_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : m_div_sequencer
// Description : Issue/sequencing controller for the iterative M-extension
//               divider. Resolves divide-by-zero, signed overflow and
//               non-divide opcodes locally, otherwise launches the unsigned
//               divider on operand magnitudes and sign-corrects the result.
//               Optional feature macro: M_DIV_FUSE_EN (reuse of the last
//               divider result for a request with identical operands).
// Revision    : 1.0 - initial release
// ============================================================================
module m_div_sequencer #(
  parameter int XLEN    = 32,
  parameter int TAG_W   = 5,
  parameter int TIMEOUT = 64
) (
  input  logic            clk,
  input  logic            rst_n,
  m_div_sequencer_if.slave bus,
  input  logic            flush,
  output logic            div_start,
  output logic [XLEN-1:0] div_a,
  output logic [XLEN-1:0] div_b,
  input  logic            div_done,
  input  logic [XLEN-1:0] div_q,
  input  logic [XLEN-1:0] div_r,
  output logic            m_busy,
  output logic            err_timeout
);

  localparam int              c_CNT_W    = $clog2(TIMEOUT + 1);
  localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(TIMEOUT - 1);
  localparam logic [XLEN-1:0] c_MIN      = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [XLEN-1:0] c_ONES     = {XLEN{1'b1}};

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LAUNCH = 3'd1,
    S_WAIT   = 3'd2,
    S_FIXUP  = 3'd3,
    S_HOLD   = 3'd4,
    S_DRAIN  = 3'd5
  } state_t;

  state_t             r_state;
  logic               r_sa;
  logic               r_sb;
  logic               r_signed;
  logic               r_is_rem;
  logic [TAG_W-1:0]   r_tag;
  logic [XLEN-1:0]    r_q;
  logic [XLEN-1:0]    r_r;
  logic [c_CNT_W-1:0] r_cnt;

  logic               w_accept;
  logic               w_signed;
  logic               w_is_div;
  logic               w_is_rem;
  logic               w_b_zero;
  logic               w_ovf;
  logic               w_special;
  logic [XLEN-1:0]    w_special_res;
  logic [XLEN-1:0]    w_mag_a;
  logic [XLEN-1:0]    w_mag_b;
  logic [XLEN-1:0]    w_q_fix;
  logic [XLEN-1:0]    w_r_fix;
  logic [XLEN-1:0]    w_fix_res;
  logic               w_fuse_hit;
  logic [XLEN-1:0]    w_fuse_q;
  logic [XLEN-1:0]    w_fuse_r;

  // Handshake/stall status follows directly from the registered state
  assign bus.req_ready = (r_state == S_IDLE);
  assign m_busy        = (r_state != S_IDLE);
  assign w_accept      = (r_state == S_IDLE) && bus.req_valid && !flush;

  // Decode the incoming request and pre-compute corner-case results and magnitudes
  always_comb begin
    w_signed      = ~bus.req_op[0];
    w_is_div      = (bus.req_op[3:2] == 2'b10);
    w_is_rem      = bus.req_op[1];
    w_b_zero      = (bus.req_b == '0);
    w_ovf         = w_signed && (bus.req_a == c_MIN) && (bus.req_b == c_ONES);
    w_special     = !w_is_div || w_b_zero || w_ovf;
    w_special_res = '0;
    if (!w_is_div) begin
      w_special_res = '0;
    end else if (w_b_zero) begin
      w_special_res = w_is_rem ? bus.req_a : c_ONES;
    end else if (w_ovf) begin
      w_special_res = w_is_rem ? '0 : c_MIN;
    end
    w_mag_a = (w_signed && bus.req_a[XLEN-1]) ? ('0 - bus.req_a) : bus.req_a;
    w_mag_b = (w_signed && bus.req_b[XLEN-1]) ? ('0 - bus.req_b) : bus.req_b;
  end

  // Sign fix-up: quotient sign is sa^sb, remainder follows the dividend
  always_comb begin
    w_q_fix   = (r_signed && (r_sa ^ r_sb)) ? ('0 - r_q) : r_q;
    w_r_fix   = (r_signed && r_sa) ? ('0 - r_r) : r_r;
    w_fix_res = r_is_rem ? w_r_fix : w_q_fix;
  end

`ifdef M_DIV_FUSE_EN
  logic            r_fz_valid;
  logic            r_fz_signed;
  logic [XLEN-1:0] r_fz_a;
  logic [XLEN-1:0] r_fz_b;
  logic [XLEN-1:0] r_fz_q;
  logic [XLEN-1:0] r_fz_r;
  logic [XLEN-1:0] r_pend_a;
  logic [XLEN-1:0] r_pend_b;

  assign w_fuse_hit = r_fz_valid && (r_fz_signed == w_signed) &&
                      (r_fz_a == bus.req_a) && (r_fz_b == bus.req_b);
  assign w_fuse_q   = r_fz_q;
  assign w_fuse_r   = r_fz_r;

  // Remember the raw operands of the launched request and the divider's answer for reuse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fz_valid  <= 1'b0;
      r_fz_signed <= 1'b0;
      r_fz_a      <= '0;
      r_fz_b      <= '0;
      r_fz_q      <= '0;
      r_fz_r      <= '0;
      r_pend_a    <= '0;
      r_pend_b    <= '0;
    end else begin
      if (w_accept) begin
        r_pend_a <= bus.req_a;
        r_pend_b <= bus.req_b;
      end
      if (flush) begin
        r_fz_valid <= 1'b0;
      end else if ((r_state == S_WAIT) && div_done) begin
        r_fz_valid  <= 1'b1;
        r_fz_signed <= r_signed;
        r_fz_a      <= r_pend_a;
        r_fz_b      <= r_pend_b;
        r_fz_q      <= div_q;
        r_fz_r      <= div_r;
      end
    end
  end
`else
  assign w_fuse_hit = 1'b0;
  assign w_fuse_q   = '0;
  assign w_fuse_r   = '0;
`endif

  // Main sequencer: state, divider launch, watchdog and registered response
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state        <= S_IDLE;
      r_sa           <= 1'b0;
      r_sb           <= 1'b0;
      r_signed       <= 1'b0;
      r_is_rem       <= 1'b0;
      r_tag          <= '0;
      r_q            <= '0;
      r_r            <= '0;
      r_cnt          <= '0;
      div_start      <= 1'b0;
      div_a          <= '0;
      div_b          <= '0;
      bus.resp_valid <= 1'b0;
      bus.resp_data  <= '0;
      bus.resp_tag   <= '0;
      err_timeout    <= 1'b0;
    end else begin
      div_start <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_sa     <= bus.req_a[XLEN-1];
            r_sb     <= bus.req_b[XLEN-1];
            r_signed <= w_signed;
            r_is_rem <= w_is_rem;
            r_tag    <= bus.req_tag;
            if (w_special) begin
              bus.resp_data  <= w_special_res;
              bus.resp_tag   <= bus.req_tag;
              bus.resp_valid <= 1'b1;
              r_state        <= S_HOLD;
            end else if (w_fuse_hit) begin
              r_q     <= w_fuse_q;
              r_r     <= w_fuse_r;
              r_state <= S_FIXUP;
            end else begin
              div_a     <= w_mag_a;
              div_b     <= w_mag_b;
              div_start <= 1'b1;
              r_state   <= S_LAUNCH;
            end
          end
        end
        S_LAUNCH: begin
          // The divider has already seen the start pulse, so a flush must still drain it
          r_cnt   <= '0;
          r_state <= flush ? S_DRAIN : S_WAIT;
        end
        S_WAIT: begin
          if (div_done) begin
            r_q     <= div_q;
            r_r     <= div_r;
            r_state <= flush ? S_IDLE : S_FIXUP;
          end else if (flush) begin
            r_cnt   <= r_cnt + 1'b1;
            r_state <= S_DRAIN;
          end else if (r_cnt >= c_CNT_LAST) begin
            err_timeout    <= 1'b1;
            bus.resp_data  <= '0;
            bus.resp_tag   <= r_tag;
            bus.resp_valid <= 1'b1;
            r_state        <= S_HOLD;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_FIXUP: begin
          if (flush) begin
            r_state <= S_IDLE;
          end else begin
            bus.resp_data  <= w_fix_res;
            bus.resp_tag   <= r_tag;
            bus.resp_valid <= 1'b1;
            r_state        <= S_HOLD;
          end
        end
        S_HOLD: begin
          // Flush wins over resp_ready; both simply retire the held result
          if (flush || bus.resp_ready) begin
            bus.resp_valid <= 1'b0;
            r_state        <= S_IDLE;
          end
        end
        S_DRAIN: begin
          if (div_done) begin
            r_state <= S_IDLE;
          end else if (r_cnt >= c_CNT_LAST) begin
            err_timeout <= 1'b1;
            r_state     <= S_IDLE;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: begin
          bus.resp_valid <= 1'b0;
          r_state        <= S_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_m_div_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_m_div_sequencer
// Description : Self-checking bench for m_div_sequencer with a behavioural
//               divider model and a response scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_m_div_sequencer;
  localparam int XLEN    = 32;
  localparam int TAG_W   = 5;
  localparam int TIMEOUT = 64;

  localparam logic [3:0] OP_DIV  = 4'b1000;
  localparam logic [3:0] OP_DIVU = 4'b1001;
  localparam logic [3:0] OP_REM  = 4'b1010;
  localparam logic [3:0] OP_REMU = 4'b1011;

`ifdef M_DIV_FUSE_EN
  localparam bit FUSE = 1'b1;
`else
  localparam bit FUSE = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            flush = 1'b0;
  logic            div_start;
  logic [XLEN-1:0] div_a;
  logic [XLEN-1:0] div_b;
  logic            div_done = 1'b0;
  logic [XLEN-1:0] div_q = '0;
  logic [XLEN-1:0] div_r = '0;
  logic            m_busy;
  logic            err_timeout;

  int checks = 0;
  int errors = 0;

  m_div_sequencer_if #(.XLEN(XLEN), .TAG_W(TAG_W)) bus ();

  m_div_sequencer #(.XLEN(XLEN), .TAG_W(TAG_W), .TIMEOUT(TIMEOUT)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus         (bus),
    .flush       (flush),
    .div_start   (div_start),
    .div_a       (div_a),
    .div_b       (div_b),
    .div_done    (div_done),
    .div_q       (div_q),
    .div_r       (div_r),
    .m_busy      (m_busy),
    .err_timeout (err_timeout)
  );

  always #5 clk = ~clk;

  // Behavioural divider: done pulses div_lat+1 cycles after the start cycle
  int              div_lat  = 2;
  bit              div_mute = 1'b0;
  int              dv_cnt   = 0;
  int              starts   = 0;
  logic [XLEN-1:0] cap_a    = '0;
  logic [XLEN-1:0] cap_b    = '0;

  always @(posedge clk) begin
    div_done <= 1'b0;
    if (dv_cnt > 0) begin
      dv_cnt <= dv_cnt - 1;
      if (dv_cnt == 1 && !div_mute) begin
        div_done <= 1'b1;
        div_q    <= (cap_b != 0) ? cap_a / cap_b : '1;
        div_r    <= (cap_b != 0) ? cap_a % cap_b : cap_a;
      end
    end
    if (div_start) begin
      dv_cnt <= div_lat;
      cap_a  <= div_a;
      cap_b  <= div_b;
      starts <= starts + 1;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, required %h", nm, act, exp);
    end
  endtask

  // Scoreboard monitor: every accepted response must match the oldest expectation
  logic [TAG_W+XLEN-1:0] sb_q[$];
  logic [TAG_W+XLEN-1:0] mon_exp;

  always @(negedge clk) begin
    if (rst_n && bus.resp_valid && bus.resp_ready && !flush) begin
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_resp: got data=%h tag=%0d, required no response",
                 bus.resp_data, bus.resp_tag);
      end else begin
        mon_exp = sb_q.pop_front();
        chk("resp_data", bus.resp_data, mon_exp[XLEN-1:0]);
        chk("resp_tag", 32'(bus.resp_tag), 32'(mon_exp[TAG_W+XLEN-1:XLEN]));
      end
    end
  end

  task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [TAG_W-1:0] tag);
    int n = 0;
    while (!bus.req_ready && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    chk("issue_req_ready", 32'(bus.req_ready), 32'd1);
    bus.req_valid = 1'b1;
    bus.req_op    = op;
    bus.req_a     = a;
    bus.req_b     = b;
    bus.req_tag   = tag;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
  endtask

  task automatic wait_resp(output int lat);
    lat = 1;
    while (!bus.resp_valid && lat < 300) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic run_op(input string nm, input logic [3:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [TAG_W-1:0] tag,
                        input logic [31:0] exp, input int exp_lat, input int exp_starts,
                        input logic [31:0] mag_a, input logic [31:0] mag_b);
    int s0;
    int lat;
    s0 = starts;
    sb_q.push_back({tag, exp});
    issue(op, a, b, tag);
    chk({nm, "_div_start"}, 32'(div_start), 32'(exp_starts));
    if (exp_starts == 1) begin
      chk({nm, "_div_a"}, div_a, mag_a);
      chk({nm, "_div_b"}, div_b, mag_b);
    end
    wait_resp(lat);
    chk({nm, "_latency"}, 32'(lat), 32'(exp_lat));
    @(posedge clk); #1;
    chk({nm, "_starts"}, 32'(starts - s0), 32'(exp_starts));
  endtask

  initial begin
    int s0;
    int n;
    int done_c;
    int lat;
    bit ok;
    bus.req_valid  = 1'b0;
    bus.req_op     = '0;
    bus.req_a      = '0;
    bus.req_b      = '0;
    bus.req_tag    = '0;
    bus.resp_ready = 1'b1;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_req_ready", 32'(bus.req_ready), 32'd1);
    chk("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
    chk("rst_div_start", 32'(div_start), 32'd0);
    chk("rst_div_a", div_a, 32'd0);
    chk("rst_div_b", div_b, 32'd0);
    chk("rst_resp_data", bus.resp_data, 32'd0);
    chk("rst_resp_tag", 32'(bus.resp_tag), 32'd0);
    chk("rst_err", 32'(err_timeout), 32'd0);
    chk("rst_busy", 32'(m_busy), 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Normal path, special cases and fused pairs (latency = div_lat + 4 with this model)
    div_lat = 2;
    run_op("div_m7_2", OP_DIV, 32'hFFFF_FFF9, 32'd2, 5'd1, 32'hFFFF_FFFD, 6, 1, 32'd7, 32'd2);
    run_op("rem_m7_2", OP_REM, 32'hFFFF_FFF9, 32'd2, 5'd2, 32'hFFFF_FFFF,
           FUSE ? 2 : 6, FUSE ? 0 : 1, 32'd7, 32'd2);
    run_op("divu_by0", OP_DIVU, 32'd5, 32'd0, 5'd3, 32'hFFFF_FFFF, 1, 0, 32'd0, 32'd0);
    run_op("remu_by0", OP_REMU, 32'd5, 32'd0, 5'd4, 32'd5, 1, 0, 32'd0, 32'd0);
    run_op("div_ovf", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 5'd5, 32'h8000_0000, 1, 0, 32'd0, 32'd0);
    run_op("rem_ovf", OP_REM, 32'h8000_0000, 32'hFFFF_FFFF, 5'd6, 32'd0, 1, 0, 32'd0, 32'd0);
    run_op("div_7_m2", OP_DIV, 32'd7, 32'hFFFF_FFFE, 5'd7, 32'hFFFF_FFFD, 6, 1, 32'd7, 32'd2);
    run_op("rem_7_m2", OP_REM, 32'd7, 32'hFFFF_FFFE, 5'd8, 32'd1,
           FUSE ? 2 : 6, FUSE ? 0 : 1, 32'd7, 32'd2);
    run_op("not_div", 4'b0000, 32'd9, 32'd3, 5'd9, 32'd0, 1, 0, 32'd0, 32'd0);
    run_op("divu_100_7", OP_DIVU, 32'd100, 32'd7, 5'd10, 32'd14, 6, 1, 32'd100, 32'd7);
    run_op("remu_100_7", OP_REMU, 32'd100, 32'd7, 5'd11, 32'd2,
           FUSE ? 2 : 6, FUSE ? 0 : 1, 32'd100, 32'd7);
    div_lat = 5;
    run_op("divu_big", OP_DIVU, 32'hFFFF_FFFF, 32'd10, 5'd12, 32'h1999_9999, 9, 1,
           32'hFFFF_FFFF, 32'd10);

    // Flush in the second WAIT cycle; sequencer drains the divider silently
    div_lat = 10;
    s0 = starts;
    issue(OP_DIV, 32'd20, 32'd3, 5'd13);
    @(posedge clk); #1;
    @(posedge clk); #1;
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    ok = 1'b1;
    done_c = -100;
    n = 4;
    while (!bus.req_ready && n < 100) begin
      if (!m_busy || bus.resp_valid) ok = 1'b0;
      if (div_done) done_c = n;
      @(posedge clk); #1;
      n++;
    end
    chk("drain_req_ready", 32'(bus.req_ready), 32'd1);
    chk("drain_ready_after_done", 32'(n), 32'(done_c + 1));
    chk("drain_busy_no_resp", 32'(ok), 32'd1);
    chk("drain_starts", 32'(starts - s0), 32'd1);

    // Back-pressure in HOLD, then flush together with resp_ready
    div_lat = 2;
    bus.resp_ready = 1'b0;
    issue(OP_DIVU, 32'd5, 32'd0, 5'd14);
    ok = 1'b1;
    for (int i = 0; i < 5; i++) begin
      if (!bus.resp_valid || bus.req_ready || bus.resp_data !== 32'hFFFF_FFFF ||
          bus.resp_tag !== 5'd14) ok = 1'b0;
      @(posedge clk); #1;
    end
    chk("hold_stable", 32'(ok), 32'd1);
    chk("hold_data", bus.resp_data, 32'hFFFF_FFFF);
    flush = 1'b1;
    bus.resp_ready = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    chk("hold_flush_valid", 32'(bus.resp_valid), 32'd0);
    chk("hold_flush_ready", 32'(bus.req_ready), 32'd1);
    chk("pre_timeout_err", 32'(err_timeout), 32'd0);

    // Divider never answers: watchdog delivers 0 and raises the sticky flag
    div_mute = 1'b1;
    sb_q.push_back({5'd15, 32'd0});
    issue(OP_DIV, 32'd9, 32'd4, 5'd15);
    wait_resp(lat);
    chk("timeout_latency", 32'(lat), 32'(TIMEOUT + 2));
    chk("timeout_err", 32'(err_timeout), 32'd1);
    @(posedge clk); #1;
    chk("timeout_err_sticky", 32'(err_timeout), 32'd1);
    chk("timeout_idle", 32'(bus.req_ready), 32'd1);

    repeat (2) @(posedge clk);
    #1;
    chk("scoreboard_drained", 32'(sb_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Global watchdog so the run always terminates
  initial begin
    #200000;
    $display("FAIL global_timeout: got no end of test, required completion");
    $fatal(1, "bench timed out");
  end

endmodule
`default_nettype wire
